alu_seq: RTL and testbench



---
 rtl/alu_seq_pkg.sv | 26 ++
 rtl/alu_seq_mul.sv | 65 ++++++
 rtl/alu_seq.sv | 143 ++++++++++++++
 tb/tb_alu_seq.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential ALU: control codes understood by the
// ALU and produced by the ALU controller, plus the ALU sequencer state encoding.
package alu_seq_pkg;

    localparam int CTRL_W = 4;

    localparam logic [CTRL_W-1:0] ALU_AND  = 4'b0000;
    localparam logic [CTRL_W-1:0] ALU_OR   = 4'b0001;
    localparam logic [CTRL_W-1:0] ALU_ADD  = 4'b0010;
    localparam logic [CTRL_W-1:0] ALU_SLTU = 4'b0011;
    localparam logic [CTRL_W-1:0] ALU_SLT  = 4'b0100;
    localparam logic [CTRL_W-1:0] ALU_MUL  = 4'b0101;
    localparam logic [CTRL_W-1:0] ALU_SUB  = 4'b0110;
    localparam logic [CTRL_W-1:0] ALU_BEQ  = 4'b0111;
    localparam logic [CTRL_W-1:0] ALU_SRA  = 4'b1000;
    localparam logic [CTRL_W-1:0] ALU_SRAV = 4'b1001;
    localparam logic [CTRL_W-1:0] ALU_BNE  = 4'b1010;
    localparam logic [CTRL_W-1:0] ALU_LUI  = 4'b1011;
    localparam logic [CTRL_W-1:0] ALU_SGT  = 4'b1100;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } alu_state_t;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative shift-add multiplier: one partial product per clock, DATA_W clocks.
// last_o/product_o are combinational so the caller can register the final result.
module alu_seq_mul
    import alu_seq_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int SH_W   = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [DATA_W-1:0] mcand_i,
    input  logic [DATA_W-1:0] mplier_i,
    output logic              last_o,
    output logic [DATA_W-1:0] product_o
);

    logic [DATA_W-1:0] mcand_r;
    logic [DATA_W-1:0] mplier_r;
    logic [DATA_W-1:0] acc_r;
    logic [SH_W-1:0]   count_r;
    logic              active_r;
    logic [DATA_W-1:0] acc_next_s;
    logic              last_s;

    // Partial-product accumulate for the current iteration.
    always_comb begin
        acc_next_s = acc_r;
        if (mplier_r[0]) begin
            acc_next_s = acc_r + mcand_r;
        end else begin
            acc_next_s = acc_r;
        end
    end

    assign last_s    = active_r && (count_r == {SH_W{1'b1}});
    assign last_o    = last_s;
    assign product_o = acc_next_s;

    // Operand latch and per-iteration shift/count update.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mcand_r  <= {DATA_W{1'b0}};
            mplier_r <= {DATA_W{1'b0}};
            acc_r    <= {DATA_W{1'b0}};
            count_r  <= {SH_W{1'b0}};
            active_r <= 1'b0;
        end else if (start_i) begin
            mcand_r  <= mcand_i;
            mplier_r <= mplier_i;
            acc_r    <= {DATA_W{1'b0}};
            count_r  <= {SH_W{1'b0}};
            active_r <= 1'b1;
        end else if (active_r) begin
            acc_r    <= acc_next_s;
            mcand_r  <= mcand_r << 1;
            mplier_r <= mplier_r >> 1;
            count_r  <= count_r + {{(SH_W-1){1'b0}}, 1'b1};
            active_r <= !last_s;
        end else begin
            active_r <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle ops complete one clock after start, multiply
// runs in alu_seq_mul while busy_o holds off new requests.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int SH_W   = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [3:0]        ctrl_i,
    input  logic [DATA_W-1:0] src1_i,
    input  logic [DATA_W-1:0] src2_i,
    input  logic [SH_W-1:0]   shamt_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] result_o,
    output logic              zero_o
);

    alu_state_t        state_r;
    alu_state_t        state_next_s;
    logic              busy_r;
    logic              busy_next_s;
    logic              done_r;
    logic              done_next_s;
    logic [DATA_W-1:0] result_r;
    logic [DATA_W-1:0] result_next_s;
    logic              zero_r;
    logic              zero_next_s;
    logic [DATA_W-1:0] alu_res_s;
    logic              mul_start_s;
    logic              mul_last_s;
    logic [DATA_W-1:0] mul_product_s;

    // bne inverts the sense so that zero_o=1 always means "branch taken".
    function automatic logic branch_flag(input logic [3:0] code, input logic [DATA_W-1:0] res);
        if (code == ALU_BNE) begin
            return (res != {DATA_W{1'b0}});
        end else begin
            return (res == {DATA_W{1'b0}});
        end
    endfunction

    alu_seq_mul #(
        .DATA_W (DATA_W),
        .SH_W   (SH_W)
    ) u_mul (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (mul_start_s),
        .mcand_i   (src1_i),
        .mplier_i  (src2_i),
        .last_o    (mul_last_s),
        .product_o (mul_product_s)
    );

    // Single-cycle operation results; mul and unused codes produce zero here.
    always_comb begin
        alu_res_s = {DATA_W{1'b0}};
        case (ctrl_i)
            ALU_AND:  alu_res_s = src1_i & src2_i;
            ALU_OR:   alu_res_s = src1_i | src2_i;
            ALU_ADD:  alu_res_s = src1_i + src2_i;
            ALU_SLTU: alu_res_s = {{(DATA_W-1){1'b0}}, (src1_i < src2_i)};
            ALU_SLT:  alu_res_s = {{(DATA_W-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
            ALU_SUB,
            ALU_BEQ,
            ALU_BNE:  alu_res_s = src1_i - src2_i;
            ALU_SRA:  alu_res_s = $signed(src2_i) >>> shamt_i;
            ALU_SRAV: alu_res_s = $signed(src2_i) >>> src1_i[SH_W-1:0];
            ALU_LUI:  alu_res_s = {src2_i[DATA_W/2-1:0], {(DATA_W/2){1'b0}}};
            ALU_SGT:  alu_res_s = {{(DATA_W-1){1'b0}}, ($signed(src1_i) > $signed(src2_i))};
            default:  alu_res_s = {DATA_W{1'b0}};
        endcase
    end

    // Sequencer next-state and next-output logic.
    always_comb begin
        state_next_s  = state_r;
        busy_next_s   = busy_r;
        done_next_s   = 1'b0;
        result_next_s = result_r;
        zero_next_s   = zero_r;
        mul_start_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_i) begin
                    if (ctrl_i == ALU_MUL) begin
                        mul_start_s  = 1'b1;
                        state_next_s = ST_MUL;
                        busy_next_s  = 1'b1;
                    end else begin
                        done_next_s   = 1'b1;
                        result_next_s = alu_res_s;
                        zero_next_s   = branch_flag(ctrl_i, alu_res_s);
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (mul_last_s) begin
                    state_next_s  = ST_IDLE;
                    busy_next_s   = 1'b0;
                    done_next_s   = 1'b1;
                    result_next_s = mul_product_s;
                    zero_next_s   = (mul_product_s == {DATA_W{1'b0}});
                end else begin
                    state_next_s = ST_MUL;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                busy_next_s  = 1'b0;
            end
        endcase
    end

    // State and registered output update; reset aborts any multiply in flight.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r  <= ST_IDLE;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            result_r <= {DATA_W{1'b0}};
            zero_r   <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            busy_r   <= busy_next_s;
            done_r   <= done_next_s;
            result_r <= result_next_s;
            zero_r   <= zero_next_s;
        end
    end

    assign busy_o   = busy_r;
    assign done_o   = done_r;
    assign result_o = result_r;
    assign zero_o   = zero_r;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: stimulus pushes hand-computed expectations,
// a monitor pops and compares on every done_o pulse.
module tb_alu_seq;
    import alu_seq_pkg::*;

    typedef struct {
        logic [31:0] res;
        logic        zero;
        string       name;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  ctrl;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [4:0]  shamt;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        zero;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    alu_seq #(.DATA_W(32), .SH_W(5)) dut (
        .clk_i    (clk),
        .rst_i    (rst_n),
        .start_i  (start),
        .ctrl_i   (ctrl),
        .src1_i   (src1),
        .src2_i   (src2),
        .shamt_i  (shamt),
        .busy_o   (busy),
        .done_o   (done),
        .result_o (result),
        .zero_o   (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, got, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got result 0x%08h with no request outstanding", result);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.name, "_result"}, result, e.res);
                check({e.name, "_zero"}, {31'd0, zero}, {31'd0, e.zero});
            end
        end
    end

    task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input logic [31:0] er, input logic ez, input string nm);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        ctrl  = c;
        src1  = a;
        src2  = b;
        shamt = sh;
        e.res  = er;
        e.zero = ez;
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        start = 1'b0;
        src1  = 32'hDEAD_BEEF;
        src2  = 32'h0BAD_F00D;
    endtask

    task automatic wait_not_busy(input string nm);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: busy still 1 after 100 cycles, expected 0", nm);
        end
        @(negedge clk);
    endtask

    initial begin
        int busy_cnt;
        int done_at;
        rst_n = 1'b0;
        start = 1'b0;
        ctrl  = 4'd0;
        src1  = 32'd0;
        src2  = 32'd0;
        shamt = 5'd0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_zero", {31'd0, zero}, 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_done", {31'd0, done}, 32'd0);

        // Back-to-back add then sub: done on two consecutive cycles.
        issue(ALU_ADD, 32'd7, 32'd5, 5'd0, 32'd12, 1'b0, "add");
        issue(ALU_SUB, 32'd5, 32'd5, 5'd0, 32'd0, 1'b1, "sub");
        check("b2b_done1", {31'd0, done}, 32'd1);
        idle();
        check("b2b_done2", {31'd0, done}, 32'd1);
        check("b2b_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("b2b_done_low", {31'd0, done}, 32'd0);

        issue(ALU_AND,  32'h0000_F0F0, 32'h0000_FF00, 5'd0, 32'h0000_F000, 1'b0, "and");
        issue(ALU_OR,   32'h0000_F0F0, 32'h0000_FF00, 5'd0, 32'h0000_FFF0, 1'b0, "or");
        issue(ALU_SLT,  32'hFFFF_FFFF, 32'd1, 5'd0, 32'd1, 1'b0, "slt");
        issue(ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd0, 1'b1, "sltu");
        issue(ALU_SGT,  32'd3, 32'hFFFF_FFFE, 5'd0, 32'd1, 1'b0, "sgt");
        issue(ALU_SRA,  32'd0, 32'h8000_0000, 5'd4, 32'hF800_0000, 1'b0, "sra");
        issue(ALU_SRAV, 32'd33, 32'hFFFF_FFF8, 5'd0, 32'hFFFF_FFFC, 1'b0, "srav");
        issue(ALU_LUI,  32'd0, 32'h0000_1234, 5'd0, 32'h1234_0000, 1'b0, "lui");
        issue(ALU_BEQ,  32'd9, 32'd9, 5'd0, 32'd0, 1'b1, "beq_eq");
        issue(ALU_BNE,  32'd9, 32'd9, 5'd0, 32'd0, 1'b0, "bne_eq");
        issue(ALU_BNE,  32'd9, 32'd8, 5'd0, 32'd1, 1'b1, "bne_ne");
        issue(4'b1110,  32'd9, 32'd8, 5'd0, 32'd0, 1'b1, "undef");
        idle();
        @(negedge clk);

        // Multiply with an ignored start pulse in the middle.
        issue(ALU_MUL, 32'hFFFF_FFFD, 32'd7, 5'd0, 32'hFFFF_FFEB, 1'b0, "mul");
        idle();
        busy_cnt = 0;
        done_at  = -1;
        for (int i = 0; i < 40; i++) begin
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) begin
                done_at = i;
                break;
            end
            if (i == 5) begin
                start = 1'b1;
                ctrl  = ALU_ADD;
                src1  = 32'd1;
                src2  = 32'd2;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        check("mul_busy_cycles", busy_cnt, 32'd32);
        check("mul_done_cycle", done_at, 32'd32);
        check("mul_busy_at_done", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("mul_done_pulse", {31'd0, done}, 32'd0);

        issue(ALU_MUL, 32'd0, 32'h0000_1234, 5'd0, 32'd0, 1'b1, "mul_zero");
        idle();
        wait_not_busy("mul_zero");
        @(negedge clk);

        // Abort a multiply with reset after 10 busy cycles.
        @(negedge clk);
        start = 1'b1;
        ctrl  = ALU_MUL;
        src1  = 32'd5;
        src2  = 32'd6;
        idle();
        repeat (10) @(negedge clk);
        check("abort_busy_before", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_result", result, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("abort_no_busy", {31'd0, busy}, 32'd0);

        issue(ALU_ADD, 32'd1, 32'd1, 5'd0, 32'd2, 1'b0, "add_after_abort");
        idle();
        repeat (3) @(negedge clk);

        check("scoreboard_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
